seg7_ca_capture_decoder: RTL and testbench
==========================================

// Module: seg7_ca_capture_decoder
// PURPOSE
//  Receive side of the common-anode 7-segment driver interface. Samples the
//  multiplexed segment/anode/decimal-point lines, waits for a stable pattern,
//  and decodes each digit back to a 4-bit value. Used as a display monitor and
//  as a self-check for the display drivers.
// PARAMETERS
//  DIGITS         4   number of anode lines / digits captured (1..8)
//  STABLE_CYCLES  8   consecutive identical samples needed before capture (>=2)
// PORTS
//  clk          in   1          system clock (50 MHz)
//  rst          in   1          synchronous reset, active-high
//  seg_in       in   7          segments, active-low, [0]=a..[6]=g
//  bp_in        in   1          decimal point, active-low
//  an_in        in   DIGITS     anode selects, active-low
//  bcd_out      out  4*DIGITS   decoded value; digit i at [4i+3:4i]
//  bp_out       out  DIGITS     decimal point per digit, active-high
//  digit_valid  out  DIGITS     digit i holds a legal, non-blank value
//  digit_err    out  DIGITS     sticky: illegal pattern seen on digit i
//  bus_err      out  1          sticky: >1 anode low in a stable sample
//  upd          out  1          1-cycle pulse: a digit register was written
//  upd_idx      out  3          index of digit written with upd
// BEHAVIOUR
//  - Reset: all outputs 0; sync stages, counter and captured flag cleared.
//  - Input sync: 2-FF synchronizer on {an_in,bp_in,seg_in}; V = 2nd stage.
//  - Stability counter cnt: 0 when V differs from previous V; otherwise +1,
//    saturating at STABLE_CYCLES. Capture fires in the cycle where cnt goes
//    STABLE_CYCLES-1 -> STABLE_CYCLES; at most one capture per stable period.
//  - Latency: pin change to upd high = STABLE_CYCLES+3 clocks.
//  - Capture states: IDLE (cnt<STABLE_CYCLES), CAPTURE (1 cycle), HOLD (stable,
//    already captured); any change of V -> IDLE.
//  - At capture, an_in low-count decides:
//    none low -> no write, no upd.
//    exactly one low (digit i) -> write digit i, upd=1, upd_idx=i.
//    >1 low -> bus_err<=1, no write, no upd.
//  - Decode of seg (hex, active-low):
//    0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10
//    A=08 b=03 C=46 d=21 E=06 F=0E; blank=7F.
//    legal: bcd<=value, digit_valid[i]<=1, bp_out[i]<=~bp.
//    blank: digit_valid[i]<=0, bcd kept, bp_out[i]<=~bp.
//    other: digit_valid[i]<=0, digit_err[i]<=1, bcd and bp_out kept.
//  - digit_err/bus_err clear only on rst. Digits not written keep their state.
//  - rst mid-stable-period: counter restarts. The same pattern is captured again
//    after STABLE_CYCLES+3.
// CONFIGURATION
//  DECODE_HEX_EN defined: patterns A..F decode to 4'hA..4'hF as legal.
//  DECODE_HEX_EN undefined: only 0..9 legal. A..F patterns are illegal and set
//    digit_err.
// TESTING
//  1 rst high 2 cycles -> all outputs 0; upd stays 0 during rst.
//  2 an_in=4'b1110, seg_in=7'h30, bp_in=0 held -> upd 1 cycle at +11 clocks,
//    upd_idx=0, bcd_out[3:0]=3, bp_out[0]=1, digit_valid[0]=1.
//  3 pattern toggles every 5 cycles (STABLE_CYCLES=8) -> upd never asserts.
//  4 an_in=4'b0011 stable -> bus_err=1, upd=0, digit regs unchanged.
//  5 an_in=4'b1011, seg_in=7'h08 -> with DECODE_HEX_EN: bcd digit2=4'hA, valid;
//    without: digit_err[2]=1, digit_valid[2]=0.
//  6 4-digit mux sweep of "1234", 1 ms per digit -> digits read 1,2,3,4.
//    Each digit gets exactly one upd per dwell.

Source files
------------

// File: rtl/seg7_ca_capture_decoder.sv
// Capture/decode side of a multiplexed common-anode 7-segment bus: synchronizes the pins,
// waits for a stable pattern, and decodes the addressed digit. Define DECODE_HEX_EN to accept A..F.
module seg7_ca_capture_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_in,
    input  logic                  bp_in,
    input  logic [DIGITS-1:0]     an_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     bp_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  bus_err,
    output logic                  upd,
    output logic [2:0]            upd_idx
);
    localparam int SW = DIGITS + 8;
    localparam int CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, CAPTURE, HOLD} state_t;

    localparam logic [1:0] K_LEGAL = 2'd0;
    localparam logic [1:0] K_BLANK = 2'd1;
    localparam logic [1:0] K_BAD   = 2'd2;

    // Returns {kind, value}; patterns are active-low with bit 0 = segment a.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h40: decode_seg = {K_LEGAL, 4'h0};
            7'h79: decode_seg = {K_LEGAL, 4'h1};
            7'h24: decode_seg = {K_LEGAL, 4'h2};
            7'h30: decode_seg = {K_LEGAL, 4'h3};
            7'h19: decode_seg = {K_LEGAL, 4'h4};
            7'h12: decode_seg = {K_LEGAL, 4'h5};
            7'h02: decode_seg = {K_LEGAL, 4'h6};
            7'h78: decode_seg = {K_LEGAL, 4'h7};
            7'h00: decode_seg = {K_LEGAL, 4'h8};
            7'h10: decode_seg = {K_LEGAL, 4'h9};
`ifdef DECODE_HEX_EN
            7'h08: decode_seg = {K_LEGAL, 4'hA};
            7'h03: decode_seg = {K_LEGAL, 4'hB};
            7'h46: decode_seg = {K_LEGAL, 4'hC};
            7'h21: decode_seg = {K_LEGAL, 4'hD};
            7'h06: decode_seg = {K_LEGAL, 4'hE};
            7'h0E: decode_seg = {K_LEGAL, 4'hF};
`endif
            7'h7F:   decode_seg = {K_BLANK, 4'h0};
            default: decode_seg = {K_BAD,   4'h0};
        endcase
    endfunction

    logic [SW-1:0]          sync1_q, sync1_d, v_q, v_d, prev_q, prev_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    state_t                 state_q, state_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic [DIGITS-1:0]      bp_q, bp_d, valid_q, valid_d, err_q, err_d;
    logic                   bus_err_q, bus_err_d, upd_q, upd_d;
    logic [2:0]             upd_idx_q, upd_idx_d;

    logic                   changed;
    logic [DIGITS-1:0]      an_v;
    logic [3:0]             low_cnt;
    logic [2:0]             low_idx;
    logic [5:0]             dec;

    always_comb begin
        sync1_d   = {an_in, bp_in, seg_in};
        v_d       = sync1_q;
        prev_d    = v_q;
        changed   = (v_q != prev_q);
        an_v      = v_q[SW-1:8];
        dec       = decode_seg(v_q[6:0]);

        cnt_d     = cnt_q;
        state_d   = state_q;
        bcd_d     = bcd_q;
        bp_d      = bp_q;
        valid_d   = valid_q;
        err_d     = err_q;
        bus_err_d = bus_err_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;

        if (changed)
            cnt_d = '0;
        else if (cnt_q != CW'(STABLE_CYCLES))
            cnt_d = cnt_q + 1'b1;

        if (changed) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (cnt_q == CW'(STABLE_CYCLES - 1)) state_d = CAPTURE;
                CAPTURE: state_d = HOLD;
                default: state_d = HOLD;
            endcase
        end

        low_cnt = 4'd0;
        low_idx = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_v[i]) begin
                low_cnt = low_cnt + 4'd1;
                low_idx = 3'(i);
            end
        end

        // The write lands on the same edge that enters CAPTURE, giving STABLE_CYCLES+3 pin-to-upd.
        if (state_d == CAPTURE) begin
            if (low_cnt > 4'd1) begin
                bus_err_d = 1'b1;
            end else if (low_cnt == 4'd1) begin
                upd_d     = 1'b1;
                upd_idx_d = low_idx;
                for (int i = 0; i < DIGITS; i++) begin
                    if (!an_v[i]) begin
                        case (dec[5:4])
                            K_LEGAL: begin
                                bcd_d[4*i +: 4] = dec[3:0];
                                valid_d[i]      = 1'b1;
                                bp_d[i]         = ~v_q[7];
                            end
                            K_BLANK: begin
                                valid_d[i] = 1'b0;
                                bp_d[i]    = ~v_q[7];
                            end
                            default: begin
                                valid_d[i] = 1'b0;
                                err_d[i]   = 1'b1;
                            end
                        endcase
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= '0;
            v_q       <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            state_q   <= IDLE;
            bcd_q     <= '0;
            bp_q      <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            bus_err_q <= 1'b0;
            upd_q     <= 1'b0;
            upd_idx_q <= 3'd0;
        end else begin
            sync1_q   <= sync1_d;
            v_q       <= v_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bp_q      <= bp_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            bus_err_q <= bus_err_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign bp_out      = bp_q;
    assign digit_valid = valid_q;
    assign digit_err   = err_q;
    assign bus_err     = bus_err_q;
    assign upd         = upd_q;
    assign upd_idx     = upd_idx_q;

endmodule

// File: tb/tb_seg7_ca_capture_decoder.sv
// Directed bench for seg7_ca_capture_decoder: vector table plus reset, toggle,
// mid-period reset and mux-sweep sequences (DIGITS=4, STABLE_CYCLES=8).
module tb_seg7_ca_capture_decoder;
`ifdef DECODE_HEX_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic        bp_in;
    logic [3:0]  an_in;
    logic [15:0] bcd_out;
    logic [3:0]  bp_out;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_err;
    logic        bus_err;
    logic        upd;
    logic [2:0]  upd_idx;

    int checks = 0;
    int errors = 0;

    seg7_ca_capture_decoder #(.DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .bp_in(bp_in), .an_in(an_in),
        .bcd_out(bcd_out), .bp_out(bp_out), .digit_valid(digit_valid),
        .digit_err(digit_err), .bus_err(bus_err), .upd(upd), .upd_idx(upd_idx)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        bp;
        int          exp_upds;
        logic [2:0]  exp_idx;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_bp;
        logic [3:0]  exp_valid;
        logic [3:0]  exp_err;
        logic        exp_bus;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Observe n clocks, sampling 1 time unit after each rising edge.
    task automatic watch(input int n, output int pulses, output int first, output logic [2:0] idx);
        pulses = 0;
        first  = -1;
        idx    = 3'd0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk);
            #1;
            if (upd === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    idx   = upd_idx;
                end
            end
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic bp);
        an_in  = an;
        seg_in = seg;
        bp_in  = bp;
    endtask

    initial begin
        int pulses, first, total;
        logic [2:0] idx;
        logic [6:0] sweep_seg[4];

        tbl[0] = '{4'b1110, 7'h30, 1'b0, 1, 3'd0, 16'h0003, 4'b0001, 4'b0001, 4'b0000, 1'b0};
        tbl[1] = '{4'b1101, 7'h24, 1'b1, 1, 3'd1, 16'h0023, 4'b0001, 4'b0011, 4'b0000, 1'b0};
        tbl[2] = '{4'b1011, 7'h08, 1'b1, 1, 3'd2, HEX ? 16'h0A23 : 16'h0023, 4'b0001,
                   HEX ? 4'b0111 : 4'b0011, HEX ? 4'b0000 : 4'b0100, 1'b0};
        tbl[3] = '{4'b0111, 7'h7F, 1'b0, 1, 3'd3, HEX ? 16'h0A23 : 16'h0023, 4'b1001,
                   HEX ? 4'b0111 : 4'b0011, HEX ? 4'b0000 : 4'b0100, 1'b0};
        tbl[4] = '{4'b0011, 7'h79, 1'b1, 0, 3'd0, HEX ? 16'h0A23 : 16'h0023, 4'b1001,
                   HEX ? 4'b0111 : 4'b0011, HEX ? 4'b0000 : 4'b0100, 1'b1};
        tbl[5] = '{4'b1111, 7'h12, 1'b1, 0, 3'd0, HEX ? 16'h0A23 : 16'h0023, 4'b1001,
                   HEX ? 4'b0111 : 4'b0011, HEX ? 4'b0000 : 4'b0100, 1'b1};
        tbl[6] = '{4'b1110, 7'h55, 1'b1, 1, 3'd0, HEX ? 16'h0A23 : 16'h0023, 4'b1001,
                   HEX ? 4'b0110 : 4'b0010, HEX ? 4'b0001 : 4'b0101, 1'b1};
        tbl[7] = '{4'b1110, 7'h02, 1'b1, 1, 3'd0, HEX ? 16'h0A26 : 16'h0026, 4'b1000,
                   HEX ? 4'b0111 : 4'b0011, HEX ? 4'b0001 : 4'b0101, 1'b1};

        sweep_seg[0] = 7'h79;
        sweep_seg[1] = 7'h24;
        sweep_seg[2] = 7'h30;
        sweep_seg[3] = 7'h19;

        // Reset: outputs cleared and upd low throughout
        rst = 1'b1;
        drive(4'b1111, 7'h7F, 1'b1);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            check("rst_upd", {31'd0, upd}, 32'd0);
        end
        check("rst_outputs", {bcd_out, bp_out, digit_valid, digit_err, bus_err, upd_idx},
              32'd0);
        rst = 1'b0;
        watch(12, pulses, first, idx);
        check("idle_no_upd", pulses, 0);

        for (int v = 0; v < 8; v++) begin
            drive(tbl[v].an, tbl[v].seg, tbl[v].bp);
            watch(16, pulses, first, idx);
            check($sformatf("v%0d_upd_count", v), pulses, tbl[v].exp_upds);
            if (tbl[v].exp_upds > 0) begin
                check($sformatf("v%0d_latency", v), first, 11);
                check($sformatf("v%0d_upd_idx", v), {29'd0, idx}, {29'd0, tbl[v].exp_idx});
            end
            check($sformatf("v%0d_bcd", v), {16'd0, bcd_out}, {16'd0, tbl[v].exp_bcd});
            check($sformatf("v%0d_bp", v), {28'd0, bp_out}, {28'd0, tbl[v].exp_bp});
            check($sformatf("v%0d_valid", v), {28'd0, digit_valid}, {28'd0, tbl[v].exp_valid});
            check($sformatf("v%0d_err", v), {28'd0, digit_err}, {28'd0, tbl[v].exp_err});
            check($sformatf("v%0d_bus", v), {31'd0, bus_err}, {31'd0, tbl[v].exp_bus});
        end

        // Pattern toggling faster than the stability window never captures
        total = 0;
        for (int t = 0; t < 8; t++) begin
            drive(4'b1110, (t % 2 == 0) ? 7'h40 : 7'h79, 1'b1);
            watch(5, pulses, first, idx);
            total += pulses;
        end
        check("toggle_no_upd", total, 0);
        check("toggle_bcd_kept", {16'd0, bcd_out}, {16'd0, tbl[7].exp_bcd});

        // Reset in the middle of a stable period: full latency starts over
        drive(4'b1101, 7'h19, 1'b1);
        watch(6, pulses, first, idx);
        check("midrst_pre_upd", pulses, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_upd_low", {31'd0, upd}, 32'd0);
        check("midrst_cleared", {bcd_out, bp_out, digit_valid, digit_err, bus_err, upd_idx},
              32'd0);
        rst = 1'b0;
        watch(16, pulses, first, idx);
        check("midrst_upd_count", pulses, 1);
        check("midrst_latency", first, 11);
        check("midrst_idx", {29'd0, idx}, 32'd1);
        check("midrst_bcd", {16'd0, bcd_out}, 32'h0040);
        check("midrst_valid", {28'd0, digit_valid}, 32'h2);
        check("midrst_bp", {28'd0, bp_out}, 32'h0);

        // Multiplexed sweep: digit i shows value i+1, one upd per dwell
        for (int d = 0; d < 4; d++) begin
            drive(~(4'b0001 << d), sweep_seg[d], 1'b1);
            watch(20, pulses, first, idx);
            check($sformatf("sweep%0d_upd_count", d), pulses, 1);
            check($sformatf("sweep%0d_idx", d), {29'd0, idx}, d);
        end
        check("sweep_bcd", {16'd0, bcd_out}, 32'h4321);
        check("sweep_valid", {28'd0, digit_valid}, 32'hF);
        check("sweep_err", {27'd0, digit_err, bus_err}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
